div_radix2: RTL and testbench

Multi-cycle 32-bit integer divider feeding the EX stage of the five-stage MIPS pipeline. It executes DIV/DIVU, driving `isdivE`-qualified stall via `ready` (the hazard unit forms `divstallE = isdivE & ~divreadyE`) and delivering `{remainder, quotient}` to the HI/LO path in the ME stage. Implementation is a restoring radix-2 divider, one quotient bit per cycle, with sign fix-up for signed operation.

---
 rtl/div_radix2_if.sv | 22 ++
 rtl/div_radix2.sv | 140 ++++++++++++++
 tb/tb_div_radix2.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_radix2_if.sv
// Operand/handshake bundle between the EX stage (master) and the radix-2 divider (slave).
interface div_radix2_if #(parameter int WIDTH = 32);
   logic               start;
   logic               signed_div;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic               hold;
   logic               annul;
   logic               ready;
   logic               busy;
   logic [2*WIDTH-1:0] result;

   modport master (
      output start, signed_div, opa, opb, hold, annul,
      input  ready, busy, result
   );

   modport slave (
      input  start, signed_div, opa, opb, hold, annul,
      output ready, busy, result
   );
endinterface

// File: rtl/div_radix2.sv
// Restoring radix-2 DIV/DIVU unit, one quotient bit per cycle, result = {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes the cycle after start.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        resetn,
   div_radix2_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

   stateType           state;
   stateType           nextState;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   dvdQuot;
   logic [CW-1:0]      cnt;
   logic               isSigned;
   logic               negQuot;
   logic               negRem;
   logic               divZero;
   logic [2*WIDTH-1:0] result;

   logic               startAccept;
   logic               opbZero;
   logic               fastZero;
   logic               lastIter;
   logic [WIDTH-1:0]   opaMag;
   logic [WIDTH-1:0]   opbMag;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   remNext;
   logic [WIDTH-1:0]   dvdQuotNext;
   logic [WIDTH-1:0]   quotFinal;
   logic [WIDTH-1:0]   remFinal;

   assign startAccept = (state == IDLE) && bus.start && !bus.annul;
   assign opbZero     = (bus.opb == '0);
   assign lastIter    = (state == BUSY) && (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
   assign fastZero = startAccept && opbZero;
`else
   assign fastZero = 1'b0;
`endif

   assign opaMag = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
   assign opbMag = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

   // The dividend shifts out of the top of dvdQuot while quotient bits enter at the bottom,
   // so after WIDTH iterations the register holds the unsigned quotient.
   assign shifted     = {rem, dvdQuot[WIDTH-1]};
   assign diff        = shifted - {1'b0, divisor};
   assign remNext     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign dvdQuotNext = {dvdQuot[WIDTH-2:0], ~diff[WIDTH]};

   // A zero divisor leaves |opa| as remainder, so the sign fix-up already restores opa.
   assign quotFinal = divZero ? {WIDTH{1'b1}}
                    : ((isSigned && negQuot) ? -dvdQuotNext : dvdQuotNext);
   assign remFinal  = (isSigned && negRem) ? -remNext : remNext;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; annul overrides every other transition.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (startAccept) begin
               nextState = fastZero ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (lastIter) begin
               nextState = DONE;
            end
         end
         DONE: begin
            if (!bus.hold) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      if (bus.annul) begin
         nextState = IDLE;
      end
   end

   // Operand capture, iteration and result write; an annulled cycle changes nothing here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         divisor  <= '0;
         rem      <= '0;
         dvdQuot  <= '0;
         cnt      <= '0;
         isSigned <= 1'b0;
         negQuot  <= 1'b0;
         negRem   <= 1'b0;
         divZero  <= 1'b0;
         result   <= '0;
      end else if (!bus.annul) begin
         if (startAccept) begin
            divisor  <= opbMag;
            dvdQuot  <= opaMag;
            rem      <= '0;
            cnt      <= '0;
            isSigned <= bus.signed_div;
            negQuot  <= bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1];
            negRem   <= bus.opa[WIDTH-1];
            divZero  <= opbZero;
            if (fastZero) begin
               result <= {bus.opa, {WIDTH{1'b1}}};
            end
         end else if (state == BUSY) begin
            rem     <= remNext;
            dvdQuot <= dvdQuotNext;
            cnt     <= cnt + CW'(1);
            if (lastIter) begin
               result <= {remFinal, quotFinal};
            end
         end
      end
   end

   assign bus.ready  = (state == DONE);
   assign bus.busy   = (state == BUSY);
   assign bus.result = result;

endmodule

// File: tb/tb_div_radix2.sv
// Directed-vector bench for div_radix2: reset, signed/unsigned results, latency, hold, back-to-back,
// annul and divide-by-zero (expected latency follows DIV_ZERO_FAST_EN).
module tb_div_radix2;

   localparam int WIDTH = 32;
   localparam int TIMEOUT = 100;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 33;
`endif

   logic clk = 1'b0;
   logic resetn;

   div_radix2_if #(.WIDTH(WIDTH)) bus ();

   div_radix2 #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int errorCount = 0;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Waits (bounded) for ready at negedges; cycles = -1 on timeout.
   task automatic waitReady(output int cycles, output int busyCycles, output logic [63:0] res);
      bit seen;
      seen = 1'b0;
      cycles = 0;
      busyCycles = 0;
      res = '0;
      while (!seen && cycles < TIMEOUT) begin
         @(negedge clk);
         cycles++;
         if (bus.busy) busyCycles++;
         if (bus.ready) begin
            seen = 1'b1;
            res = bus.result;
         end
      end
      if (!seen) cycles = -1;
   endtask

   // Called at a negedge: drives one division request and waits for its result.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output int cycles, output int busyCycles, output logic [63:0] res);
      bus.start = 1'b1;
      bus.signed_div = sgn;
      bus.opa = a;
      bus.opb = b;
      waitReady(cycles, busyCycles, res);
   endtask

   task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expRes, input int expLat);
      int cycles;
      int busyCycles;
      logic [63:0] res;
      applyStimulus(sgn, a, b, cycles, busyCycles, res);
      bus.start = 1'b0;
      checkOutput({tag, "/result"}, res, expRes);
      checkOutput({tag, "/latency"}, 64'(cycles), 64'(expLat));
      checkOutput({tag, "/busyCycles"}, 64'(busyCycles), 64'(expLat - 1));
      @(negedge clk);
      checkOutput({tag, "/readyPulse"}, {63'd0, bus.ready}, 64'd0);
   endtask

   initial begin
      int cycles;
      int busyCycles;
      int readyCount;
      int stableCount;
      logic [63:0] res;
      bit sawReady;

      resetn = 1'b0;
      bus.start = 1'b0;
      bus.signed_div = 1'b0;
      bus.opa = '0;
      bus.opb = '0;
      bus.hold = 1'b0;
      bus.annul = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset/flags", {62'd0, bus.ready, bus.busy}, 64'd0);
      checkOutput("reset/result", bus.result, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      runDiv("divu100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

      // Reset in the middle of an operation, then a clean division.
      bus.start = 1'b1;
      bus.signed_div = 1'b0;
      bus.opa = 32'hFFFF_FFFF;
      bus.opb = 32'd1;
      repeat (10) @(negedge clk);
      checkOutput("midop/busy", {63'd0, bus.busy}, 64'd1);
      resetn = 1'b0;
      bus.start = 1'b0;
      #1;
      checkOutput("midreset/flags", {62'd0, bus.ready, bus.busy}, 64'd0);
      checkOutput("midreset/result", bus.result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      runDiv("postreset100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

      runDiv("divNeg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      runDiv("div7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
      runDiv("divMin_neg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
      runDiv("divuMax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
      runDiv("divuMin_neg1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);

      // Hold for three DONE cycles: ready must last four cycles with a stable result.
      applyStimulus(1'b0, 32'd1000, 32'd7, cycles, busyCycles, res);
      checkOutput("hold/result", res, {32'd6, 32'd142});
      bus.start = 1'b0;
      bus.hold = 1'b1;
      readyCount = (cycles > 0) ? 1 : 0;
      stableCount = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.ready) readyCount++;
         if (bus.result == {32'd6, 32'd142}) stableCount++;
      end
      bus.hold = 1'b0;
      @(negedge clk);
      checkOutput("hold/readyCycles", 64'(readyCount), 64'd4);
      checkOutput("hold/stable", 64'(stableCount), 64'd3);
      checkOutput("hold/release", {63'd0, bus.ready}, 64'd0);

      // Back-to-back: start stays high, operands change once the first result is seen.
      applyStimulus(1'b0, 32'd9, 32'd3, cycles, busyCycles, res);
      checkOutput("b2b/first", res, {32'd0, 32'd3});
      bus.opa = 32'd10;
      bus.opb = 32'd4;
      waitReady(cycles, busyCycles, res);
      bus.start = 1'b0;
      checkOutput("b2b/second", res, {32'd2, 32'd2});
      checkOutput("b2b/gap", 64'(cycles), 64'd34);
      @(negedge clk);

      // Annul mid-iteration with start still high: back to IDLE, result untouched.
      applyStimulus(1'b0, 32'd77, 32'd7, cycles, busyCycles, res);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.opa = 32'd123;
      bus.opb = 32'd5;
      repeat (11) @(negedge clk);
      bus.annul = 1'b1;
      @(negedge clk);
      checkOutput("annul/flags", {62'd0, bus.ready, bus.busy}, 64'd0);
      checkOutput("annul/result", bus.result, {32'd0, 32'd11});
      bus.annul = 1'b0;
      bus.start = 1'b0;
      sawReady = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.ready || bus.busy) sawReady = 1'b1;
      end
      checkOutput("annul/quiet", {63'd0, sawReady}, 64'd0);

      // Annul together with start in IDLE must not launch a division.
      bus.start = 1'b1;
      bus.annul = 1'b1;
      @(negedge clk);
      checkOutput("annulStart/busy", {63'd0, bus.busy}, 64'd0);
      bus.start = 1'b0;
      bus.annul = 1'b0;
      @(negedge clk);
      runDiv("postannul50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

      runDiv("divuZero", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, ZERO_LAT);
      runDiv("divZeroNeg", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, ZERO_LAT);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
